mod_counter_ctrl: RTL

- Controller plus embedded counter core that sequences a programmable-modulus up-counter. Replaces hard-wired NAND clear decoding with a registered modulus and start/stop/pause control.
- Sits between a host (configuration and commands) and counter consumers, which use the count value and the terminal-count strobe.
- Fully synchronous to clk. Asynchronous active-low clear clr.

---
 rtl/mod_ctrl_pkg.sv | 14 +
 rtl/mod_n_count_core.sv | 26 ++
 rtl/mod_counter_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mod_ctrl_pkg.sv
// rtl/mod_ctrl_pkg.sv - shared types and constants for the modulus counter controller
package mod_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MIN_MOD = 2;
    localparam int WRAP_W  = 8;

endpackage

// File: rtl/mod_n_count_core.sv
// rtl/mod_n_count_core.sv - WIDTH-bit up-counter that wraps to zero at mod-1
module mod_n_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sync_clear,
    input  logic [WIDTH-1:0] mod,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == mod - WIDTH'(1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (sync_clear) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_counter_ctrl.sv
// rtl/mod_counter_ctrl.sv - start/stop/pause controller around a programmable-modulus counter
// Optional MOD_CTRL_WRAPCNT_EN adds a saturating wrap_cnt output.
module mod_counter_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_MOD = 13
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef MOD_CTRL_WRAPCNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    state_t           state;
    logic [WIDTH-1:0] mod_q;
    logic             oneshot_q;
    logic             at_max;
    logic             cfg_hs;
    logic             cfg_ok;
    logic             run_start;
    logic             en;
    logic             sync_clear;

    assign cfg_ready = (state == IDLE) || (state == DONE);
    assign busy      = (state == RUN) || (state == HOLD);
    assign tc        = (state == RUN) && at_max;
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_mod >= WIDTH'(MIN_MOD));

    // stop has priority over start in every state
    always_comb begin
        run_start  = 1'b0;
        en         = 1'b0;
        sync_clear = 1'b0;
        case (state)
            IDLE, DONE: run_start = start && !stop;
            RUN:        en        = !stop;
            HOLD:       sync_clear = stop;
            default:    ;
        endcase
        if (run_start) begin
            sync_clear = 1'b1;
        end
    end

    mod_n_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .sync_clear(sync_clear),
        .mod       (mod_q),
        .count     (count),
        .at_max    (at_max)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            mod_q     <= WIDTH'(DEFAULT_MOD);
            oneshot_q <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // a same-cycle start sees the new modulus since the counter restarts from zero
            if (cfg_hs) begin
                if (cfg_ok) begin
                    mod_q     <= cfg_mod;
                    oneshot_q <= cfg_oneshot;
                    err       <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (run_start) begin
                        state <= RUN;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= HOLD;
                    end else if (at_max && oneshot_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOD_CTRL_WRAPCNT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrap_cnt <= '0;
        end else if (run_start) begin
            wrap_cnt <= '0;
        end else if (tc && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
        end
    end
`endif

endmodule
